// File: rtl/comm_frame_slave.sv
// comm_frame_slave: copter-side UART link endpoint.
// Receives 3-byte command frames (cmd, data_hi, data_lo) and presents them as one cmd/data
// word with a ready flag. Transmits single-byte responses back to the master.
//
// state      | meaning
// -----------+----------------------------------------------------------
// RX_IDLE    | line idle, watching for a synchronized 1->0 edge
// RX_START   | counting to mid start bit; a 1 there is treated as a glitch
// RX_DATA    | sampling 8 data bits, LSB first, one per bit time
// RX_STOP    | sampling the stop bit; 1 = byte accepted, 0 = framing error
// WAIT_CMD   | no partial frame; next byte is the opcode
// WAIT_HI    | opcode held; next byte is data_hi
// WAIT_LO    | opcode and data_hi held; next byte completes the frame
// TX_IDLE    | TX line high, waiting for send_resp
// TX_XMIT    | shifting start, 8 data bits and stop, each BAUD_DIV clocks
module comm_frame_slave #(
  parameter int BAUD_DIV  = 2604,
  parameter int FRAME_TMO = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        frm_err
);

  localparam int BW = $clog2(BAUD_DIV + 1);
  localparam int GW = $clog2(FRAME_TMO + 1);
  localparam logic [BW-1:0] HALF_BIT    = BW'(BAUD_DIV / 2);
  localparam logic [BW-1:0] FULL_BIT_M1 = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_ONE    = BW'(1);
  localparam logic [GW-1:0] GAP_LIMIT   = GW'(FRAME_TMO);
  localparam logic [GW-1:0] GAP_ONE     = GW'(1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO} frm_state_t;
  typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

  logic          rx_ff1, rx_sync, rx_prev;
  rx_state_t     rx_state;
  logic [BW-1:0] rx_cnt;
  logic [2:0]    rx_bits;
  logic [7:0]    rx_shift;
  logic          byte_rdy;
  logic          rx_fall;

  frm_state_t    frm_state;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    pend_cmd, pend_hi;
  logic          frame_done;

  tx_state_t     tx_state;
  logic [BW-1:0] tx_cnt;
  logic [3:0]    tx_bits;
  logic [8:0]    tx_shift;

  // Two-flop synchronizer for the asynchronous RX pin, plus one history flop for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ff1  <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_ff1  <= RX;
      rx_sync <= rx_ff1;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall    = (rx_state == RX_IDLE) && rx_prev && !rx_sync;
  assign frame_done = byte_rdy && (frm_state == WAIT_LO);

  // UART receiver: mid-bit sampling with a down-counting baud timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      byte_rdy <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      byte_rdy <= 1'b0;
      frm_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state <= RX_START;
            rx_cnt   <= HALF_BIT;
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            if (rx_sync) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              rx_cnt   <= FULL_BIT_M1;
              rx_bits  <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt - BAUD_ONE;
          end
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_cnt   <= FULL_BIT_M1;
            if (rx_bits == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              rx_bits <= rx_bits + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt - BAUD_ONE;
          end
        end
        RX_STOP: begin
          if (rx_cnt == '0) begin
            // Return to idle at mid stop bit so the next start edge is not missed.
            byte_rdy <= rx_sync;
            frm_err  <= !rx_sync;
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt - BAUD_ONE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Frame assembly with inter-byte timeout; cmd/data only change on a complete frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      frm_state <= WAIT_CMD;
      gap_cnt   <= '0;
      pend_cmd  <= '0;
      pend_hi   <= '0;
      cmd       <= '0;
      data      <= '0;
    end else if (frm_err) begin
      frm_state <= WAIT_CMD;
      gap_cnt   <= '0;
    end else if (byte_rdy) begin
      gap_cnt <= '0;
      case (frm_state)
        WAIT_CMD: begin
          pend_cmd  <= rx_shift;
          frm_state <= WAIT_HI;
        end
        WAIT_HI: begin
          pend_hi   <= rx_shift;
          frm_state <= WAIT_LO;
        end
        WAIT_LO: begin
          cmd       <= pend_cmd;
          data      <= {pend_hi, rx_shift};
          frm_state <= WAIT_CMD;
        end
        default: frm_state <= WAIT_CMD;
      endcase
    end else if (frm_state != WAIT_CMD) begin
      if (gap_cnt >= GAP_LIMIT) begin
        frm_state <= WAIT_CMD;
        gap_cnt   <= '0;
      end else begin
        gap_cnt <= gap_cnt + GAP_ONE;
      end
    end else begin
      gap_cnt <= '0;
    end
  end

  // Ready flag: a completing frame wins over any clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_rdy <= 1'b0;
    end else if (frame_done) begin
      cmd_rdy <= 1'b1;
    end else if (clr_cmd_rdy || (rx_fall && (frm_state == WAIT_CMD))) begin
      cmd_rdy <= 1'b0;
    end
  end

  // UART transmitter: start bit driven the clock after send_resp, stop bit held a full bit time.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bits   <= '0;
      tx_shift  <= '0;
      TX        <= 1'b1;
      resp_sent <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (send_resp) begin
            tx_shift  <= {1'b1, resp};
            TX        <= 1'b0;
            tx_cnt    <= FULL_BIT_M1;
            tx_bits   <= '0;
            resp_sent <= 1'b0;
            tx_state  <= TX_XMIT;
          end
        end
        TX_XMIT: begin
          if (tx_cnt == '0) begin
            if (tx_bits == 4'd9) begin
              TX        <= 1'b1;
              resp_sent <= 1'b1;
              tx_state  <= TX_IDLE;
            end else begin
              TX       <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[8:1]};
              tx_bits  <= tx_bits + 4'd1;
              tx_cnt   <= FULL_BIT_M1;
            end
          end else begin
            tx_cnt <= tx_cnt - BAUD_ONE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comm_frame_slave.sv
// Testbench for comm_frame_slave: randomized full-duplex traffic against a frame-level model,
// with expected frames/responses queued by the stimulus and checked by independent monitors.
module tb_comm_frame_slave;

  localparam int B   = 16;
  localparam int TMO = 300;

  logic        clk = 1'b0;
  logic        rst, RX, TX;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy, clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp, resp_sent, frm_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [23:0] exp_frm_q[$];
  logic [7:0]  fr_q[$];
  logic [7:0]  exp_tx_q[$];
  int          exp_err = 0;
  int          seen_err = 0;
  bit          tx_aborted = 1'b0;

  logic mon_rdy_prev = 1'b0;
  logic mon_err_prev = 1'b0;
  logic mon_tx_prev  = 1'b1;

  always #5 clk = ~clk;

  comm_frame_slave #(.BAUD_DIV(B), .FRAME_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .data(data), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent),
    .frm_err(frm_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Serial line driver: start, 8 data bits LSB first, stop (optionally corrupted to 0).
  task automatic uart_byte(input logic [7:0] b, input bit good_stop);
    logic [9:0] f;
    f = {good_stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      RX = f[k];
      repeat (B) @(negedge clk);
    end
    RX = 1'b1;
  endtask

  // Frame-level model: every third accepted byte closes a frame; errors and timeouts drop it.
  task automatic send_good(input logic [7:0] b);
    fr_q.push_back(b);
    if (fr_q.size() == 3) begin
      exp_frm_q.push_back({fr_q[0], fr_q[1], fr_q[2]});
      fr_q.delete();
    end
    uart_byte(b, 1'b1);
  endtask

  task automatic send_bad(input logic [7:0] b);
    fr_q.delete();
    exp_err++;
    uart_byte(b, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                            input int gap);
    send_good(c);
    idle(gap);
    send_good(h);
    idle(gap);
    send_good(l);
  endtask

  task automatic wait_rx_drain();
    for (int i = 0; i < 4 * B; i++) begin
      if (exp_frm_q.size() == 0) break;
      @(negedge clk);
    end
    chk("rx_drain", exp_frm_q.size(), 0);
  endtask

  // Issue one response; optionally poke a junk send_resp mid-transmission that must be ignored.
  task automatic tx_send(input logic [7:0] b, input bit junk);
    int n;
    exp_tx_q.push_back(b);
    resp = b;
    send_resp = 1'b1;
    n = 0;
    while (n < 12 * B) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        send_resp = 1'b0;
        chk("resp_sent_clr", resp_sent, 0);
      end
      if (junk && n == 3 * B) begin
        resp = ~b;
        send_resp = 1'b1;
      end
      if (junk && n == 3 * B + 1) send_resp = 1'b0;
      if (resp_sent) break;
    end
    chk("resp_latency", n, 10 * B + 1);
  endtask

  // Frame monitor: each new cmd_rdy assertion presents one frame.
  initial begin : mon_rx
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (cmd_rdy === 1'b1 && mon_rdy_prev !== 1'b1) begin
        if (exp_frm_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rx_unexpected: got cmd 0x%0h data 0x%0h, expected no frame", cmd, data);
        end else begin
          e = exp_frm_q.pop_front();
          chk("rx_frame", {cmd, data}, e);
        end
      end
      mon_rdy_prev = cmd_rdy;
    end
  end

  // Framing-error monitor: counts pulses and requires each to last one clock.
  initial begin : mon_err
    forever begin
      @(negedge clk);
      if (frm_err === 1'b1) begin
        seen_err++;
        chk("frm_err_width", mon_err_prev, 0);
      end
      mon_err_prev = frm_err;
    end
  end

  // TX monitor: decodes each character and checks every bit is held exactly B clocks.
  initial begin : mon_tx
    logic [9:0] bits;
    logic [7:0] e;
    logic       stable;
    bit         have;
    forever begin
      @(negedge clk);
      if (mon_tx_prev === 1'b1 && TX === 1'b0) begin
        have = (exp_tx_q.size() > 0);
        e = have ? exp_tx_q.pop_front() : 8'h00;
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
          if (k > 0) @(negedge clk);
          bits[k] = TX;
          repeat (B - 1) @(negedge clk);
          if (TX !== bits[k]) stable = 1'b0;
        end
        if (tx_aborted) begin
          tx_aborted = 1'b0;
        end else if (!have) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_unexpected: got bits 0x%0h, expected no transmission", bits);
        end else begin
          chk("tx_byte", bits, {1'b1, e, 1'b0});
          chk("tx_bit_timing", stable, 1);
        end
      end
      mon_tx_prev = TX;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation exceeded its time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst = 1'b1;
    RX = 1'b1;
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    resp = 8'h00;
    idle(3);
    chk("rst_tx", TX, 1);
    chk("rst_cmd", cmd, 0);
    chk("rst_data", data, 0);
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_resp_sent", resp_sent, 0);
    chk("rst_frm_err", frm_err, 0);
    rst = 1'b0;
    idle(5);

    // Basic frame
    send_frame(8'h05, 8'h01, 8'hFF, 0);
    wait_rx_drain();
    chk("no_frm_err", seen_err, 0);

    // Consumer acknowledge
    idle(20);
    send_frame(8'h02, 8'h00, 8'h50, 5);
    wait_rx_drain();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    chk("clr_cmd_rdy", cmd_rdy, 0);
    chk("clr_hold_cmd", cmd, 8'h02);
    chk("clr_hold_data", data, 16'h0050);

    // Inter-byte timeout discards a partial frame
    send_good(8'h04);
    idle(TMO + 100);
    fr_q.delete();
    send_frame(8'h07, 8'h00, 8'h00, 3);
    wait_rx_drain();

    // Short start-bit glitch is ignored
    RX = 1'b0;
    idle(3);
    RX = 1'b1;
    idle(2 * B);
    send_frame(8'h5A, 8'hC3, 8'h81, 0);
    wait_rx_drain();

    // Stop-bit error mid-frame
    send_good(8'h11);
    send_bad(8'hE7);
    idle(10);
    send_frame(8'h06, 8'h12, 8'h34, 2);
    wait_rx_drain();
    chk("frm_err_count", seen_err, exp_err);

    // Response with an ignored second request mid-transmission
    tx_send(8'hA5, 1'b1);
    idle(7);

    // Reset in the middle of an RX byte and a TX character
    send_frame(8'h05, 8'h01, 8'hFF, 0);
    wait_rx_drain();
    chk("pre_rst_rdy", cmd_rdy, 1);
    exp_tx_q.push_back(8'h3C);
    resp = 8'h3C;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    RX = 1'b0;
    idle(3 * B);
    tx_aborted = 1'b1;
    rst = 1'b1;
    RX = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fr_q.delete();
    chk("mid_rst_tx", TX, 1);
    chk("mid_rst_cmd_rdy", cmd_rdy, 0);
    chk("mid_rst_cmd", cmd, 0);
    chk("mid_rst_data", data, 0);
    chk("mid_rst_resp_sent", resp_sent, 0);
    idle(12 * B);
    send_frame(8'h05, 8'h01, 8'hFF, 1);
    wait_rx_drain();

    // Randomized full-duplex traffic
    fork
      begin
        for (int f = 0; f < 20; f++) begin
          for (int j = 0; j < 3; j++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if ($urandom_range(0, 11) == 0) send_bad(b);
            else send_good(b);
            idle($urandom_range(0, 40));
          end
          if ($urandom_range(0, 1) == 1) begin
            clr_cmd_rdy = 1'b1;
            @(negedge clk);
            clr_cmd_rdy = 1'b0;
            chk("rand_clr_rdy", cmd_rdy, 0);
          end
          idle($urandom_range(0, 40));
        end
      end
      begin
        for (int t = 0; t < 12; t++) begin
          tx_send(8'($urandom), 1'($urandom_range(0, 1)));
          idle($urandom_range(0, 30));
        end
      end
    join

    idle(20);
    wait_rx_drain();
    chk("final_frm_err_count", seen_err, exp_err);
    chk("final_tx_queue", exp_tx_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
